// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two requesters (0 = ALU, 1 = LSU) share the port through a round-robin arbiter.
// A per-register pending-write scoreboard tracks outstanding writes for issue.

// Pending-write counter for one architectural register.
module regfile_wb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Inc and dec at the same edge cancel; dec of an empty counter saturates at 0.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                               r_cnt <= '0;
    else if (i_inc && !i_dec)                   r_cnt <= r_cnt + 1'b1;
    else if (i_dec && !i_inc && r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ADDR_W-1:0] i_req0_reg,
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ADDR_W-1:0] i_req1_reg,
  input  logic [DATA_W-1:0] i_req1_data,
  input  logic              i_rsv_valid,
  output logic              o_rsv_ready,
  input  logic [ADDR_W-1:0] i_rsv_reg,
  input  logic [ADDR_W-1:0] i_rd_reg0,
  input  logic [ADDR_W-1:0] i_rd_reg1,
  output logic              o_rd_busy0,
  output logic              o_rd_busy1,
  output logic              o_wb_chip_en,
  output logic              o_wb_write_en,
  output logic [ADDR_W-1:0] o_wb_reg,
  output logic [DATA_W-1:0] o_wb_data
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // r_last = 1 means requester 1 was granted most recently.
  logic              r_last;
  logic              r_ce, r_we;
  logic [ADDR_W-1:0] r_reg;
  logic [DATA_W-1:0] r_data;

  logic              w_gnt0, w_gnt1, w_gnt;
  logic [ADDR_W-1:0] w_gnt_reg;
  logic [DATA_W-1:0] w_gnt_data;
  logic [NREG-1:0][CNT_W-1:0] w_cnt;

  assign w_gnt0     = i_req0_valid && (!i_req1_valid || r_last);
  assign w_gnt1     = i_req1_valid && (!i_req0_valid || !r_last);
  assign w_gnt      = w_gnt0 || w_gnt1;
  assign w_gnt_reg  = w_gnt1 ? i_req1_reg  : i_req0_reg;
  assign w_gnt_data = w_gnt1 ? i_req1_data : i_req0_data;

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // Round-robin pointer moves only when someone is granted (register 0 included).
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)    r_last <= 1'b1;
    else if (w_gnt)  r_last <= w_gnt1;
  end

  // Registered write port; register 0 grants consume the slot but never write.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ce   <= 1'b0;
      r_we   <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
    end else begin
      r_ce <= w_gnt && (w_gnt_reg != '0);
      r_we <= w_gnt && (w_gnt_reg != '0);
      if (w_gnt) begin
        r_reg  <= w_gnt_reg;
        r_data <= w_gnt_data;
      end
    end
  end

  assign o_wb_chip_en  = r_ce;
  assign o_wb_write_en = r_we;
  assign o_wb_reg      = r_reg;
  assign o_wb_data     = r_data;

  // Register 0 is hardwired zero and never tracked.
  assign w_cnt[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_cnt
      logic w_inc, w_dec;
      assign w_inc = i_rsv_valid && o_rsv_ready && (i_rsv_reg == ADDR_W'(g));
      assign w_dec = r_we && (r_reg == ADDR_W'(g));
      regfile_wb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_cnt   (w_cnt[g])
      );
    end
  endgenerate

  assign o_rsv_ready = (i_rsv_reg == '0) || (w_cnt[i_rsv_reg] != CNT_MAX);
  assign o_rd_busy0  = (w_cnt[i_rd_reg0] != '0);
  assign o_rd_busy1  = (w_cnt[i_rd_reg1] != '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writebacks are queued at grant
// time and a negedge monitor checks each one the DUT presents on the write port.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              r0v, r1v, rsvv;
  logic              r0r, r1r, rsvr;
  logic [ADDR_W-1:0] r0reg, r1reg, rsvreg, rd0, rd1;
  logic [DATA_W-1:0] r0dat, r1dat;
  logic              busy0, busy1, ce, we;
  logic [ADDR_W-1:0] wreg;
  logic [DATA_W-1:0] wdat;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] dat;
  } wb_t;
  wb_t exp_q[$];

  logic [DATA_W-1:0] rf [0:31];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req0_valid(r0v), .o_req0_ready(r0r), .i_req0_reg(r0reg), .i_req0_data(r0dat),
    .i_req1_valid(r1v), .o_req1_ready(r1r), .i_req1_reg(r1reg), .i_req1_data(r1dat),
    .i_rsv_valid(rsvv), .o_rsv_ready(rsvr), .i_rsv_reg(rsvreg),
    .i_rd_reg0(rd0), .i_rd_reg1(rd1), .o_rd_busy0(busy0), .o_rd_busy1(busy1),
    .o_wb_chip_en(ce), .o_wb_write_en(we), .o_wb_reg(wreg), .o_wb_data(wdat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] rg, input logic [DATA_W-1:0] dat);
    wb_t e;
    e.rg  = rg;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Simple register-file model fed from the write port.
  always @(posedge clk) if (we) rf[wreg] <= wdat;

  // Monitor: every presented write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got reg=%0d data=%0h expected none", wreg, wdat);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_reg", 64'(wreg), 64'(e.rg));
        chk("wb_data", 64'(wdat), 64'(e.dat));
        chk("wb_ce", 64'(ce), 64'd1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    r0v = 1; r1v = 1; rsvv = 1;
    r0reg = 3; r0dat = 32'hA0A0_0003;
    r1reg = 7; r1dat = 32'hB0B0_0007;
    rsvreg = 9; rd0 = 9; rd1 = 0;
    repeat (3) @(posedge clk);
    #1;
    // Reset with all inputs active.
    chk("rst_ce", 64'(ce), 0);
    chk("rst_we", 64'(we), 0);
    chk("rst_reg", 64'(wreg), 0);
    chk("rst_data", 64'(wdat), 0);
    chk("rst_busy0", 64'(busy0), 0);
    chk("rst_busy1", 64'(busy1), 0);
    chk("rst_rsv_ready", 64'(rsvr), 1);

    // Release with both requesting: 0,1,0,1.
    rsvv = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", 64'(r0r), 64'(k % 2 == 0));
      chk("rr_ready1", 64'(r1r), 64'(k % 2 == 1));
      if (k % 2 == 0) push(3, 32'hA0A0_0003);
      else            push(7, 32'hB0B0_0007);
      tick;
    end

    // Single write to register 5.
    r1v = 0;
    r0reg = 5; r0dat = 32'h0000_0005;
    #1;
    chk("single_ready0", 64'(r0r), 1);
    chk("single_ready1", 64'(r1r), 0);
    push(5, 32'h5);
    tick;
    r0v = 0;
    #1;
    chk("single_ce", 64'(ce), 1);
    chk("single_we", 64'(we), 1);
    chk("single_reg", 64'(wreg), 5);
    chk("single_data", 64'(wdat), 5);
    tick;
    chk("rf5", 64'(rf[5]), 5);

    // Register 0 write from requester 1: granted, not written.
    r1v = 1; r1reg = 0; r1dat = 32'hF0F0_F0F0;
    #1;
    chk("r0_ready1", 64'(r1r), 1);
    tick;
    r1v = 0;
    #1;
    chk("r0_we", 64'(we), 0);
    chk("r0_ce", 64'(ce), 0);
    // Requester 1 holds last_grant now, so requester 0 wins contention.
    r0v = 1; r0reg = 3; r0dat = 32'hC0C0_0003;
    r1v = 1; r1reg = 7; r1dat = 32'hD0D0_0007;
    #1;
    chk("r0_last_ready0", 64'(r0r), 1);
    chk("r0_last_ready1", 64'(r1r), 0);
    push(3, 32'hC0C0_0003);
    tick;
    r0v = 0; r1v = 0;

    // Reserve register 9 up to saturation.
    rsvv = 1; rsvreg = 9; rd0 = 9; rd1 = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rsv_ready", 64'(rsvr), 1);
      tick;
    end
    #1;
    chk("rsv_full", 64'(rsvr), 0);
    chk("rsv_busy0", 64'(busy0), 1);
    chk("rsv_busy1_r0", 64'(busy1), 0);
    tick;
    rsvv = 0;
    // Three writebacks to register 9 from requester 1.
    for (int k = 0; k < 3; k++) begin
      r1v = 1; r1reg = 9; r1dat = 32'h91 + k;
      #1;
      chk("wb9_ready1", 64'(r1r), 1);
      chk("wb9_busy", 64'(busy0), 1);
      push(9, 32'h91 + k);
      tick;
    end
    r1v = 0;
    #1;
    chk("wb9_busy_last1", 64'(busy0), 1);
    chk("wb9_rsv_ready", 64'(rsvr), 1);
    tick;
    chk("wb9_busy_clear", 64'(busy0), 0);

    // Reservation and writeback of register 4 at the same edge.
    rsvv = 1; rsvreg = 4; rd1 = 4;
    tick;
    rsvv = 0;
    r0v = 1; r0reg = 4; r0dat = 32'h44;
    #1;
    chk("sim_busy_pre", 64'(busy1), 1);
    push(4, 32'h44);
    tick;
    r0v = 0;
    rsvv = 1; rsvreg = 4;
    #1;
    chk("sim_we", 64'(we), 1);
    chk("sim_wreg", 64'(wreg), 4);
    chk("sim_rsv_ready", 64'(rsvr), 1);
    tick;
    rsvv = 0;
    #1;
    chk("sim_busy_n2", 64'(busy1), 1);
    tick;
    chk("sim_busy_n3", 64'(busy1), 1);
    // One more write drains the single remaining reservation.
    r0v = 1; r0reg = 4; r0dat = 32'h45;
    push(4, 32'h45);
    tick;
    r0v = 0;
    tick;
    chk("sim_busy_drained", 64'(busy1), 0);

    // Reset mid-operation drops the in-flight write and reservations.
    rsvv = 1; rsvreg = 6; rd0 = 6;
    tick;
    rsvv = 0;
    r0v = 1; r0reg = 6; r0dat = 32'h66;
    #1;
    chk("mid_busy", 64'(busy0), 1);
    tick;
    r0v = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_we", 64'(we), 0);
    chk("mid_busy_clr", 64'(busy0), 0);
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
